// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the bit-serial ALU sequencer
package alu_pkg;

  // Slice select encodings: what the slice adds to A at each bit.
  localparam logic [1:0] OP_ADD     = 2'b00;  // A + B
  localparam logic [1:0] OP_ADDNB   = 2'b01;  // A + ~B (subtract with cin=1)
  localparam logic [1:0] OP_PASS    = 2'b10;  // A + 0
  localparam logic [1:0] OP_ADDONES = 2'b11;  // A + all-ones

  // Sequencer states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_ctrl.sv
// rtl/alu_serial_ctrl.sv - drives one shared 1-bit adder slice LSB-first to build a WIDTH-bit result
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             slice_a_o,
  output logic             slice_b_o,
  output logic             slice_cin_o,
  output logic [1:0]       slice_sel_o,
  input  logic             slice_d_i,
  input  logic             slice_cout_i
);

  // Terminal bit index; compared exactly so non-power-of-2 widths stop on time.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_op;
  logic             r_cin;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_run;
  logic             w_last;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_cnt == LAST_BIT);

  // Slice inputs come straight from the latched operands; bit 0 takes the latched cin.
  always_comb begin
    slice_a_o   = 1'b0;
    slice_b_o   = 1'b0;
    slice_cin_o = 1'b0;
    slice_sel_o = 2'b00;
    if (w_run) begin
      slice_a_o   = r_a[r_cnt];
      slice_b_o   = r_b[r_cnt];
      slice_cin_o = (r_cnt == '0) ? r_cin : r_carry;
      slice_sel_o = r_op;
    end
  end

  // Sequencer: accept in IDLE, one bit per cycle in RUN, one-cycle done pulse in DONE.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_cin    <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_a      <= a_i;
            r_b      <= b_i;
            r_op     <= op_i;
            r_cin    <= cin_i;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[r_cnt] <= slice_d_i;
          r_carry         <= slice_cout_i;
          if (w_last) begin
            // r_carry here is the carry into the MSB.
            r_ovf   <= r_carry ^ slice_cout_i;
            r_cout  <= slice_cout_i;
            r_done  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = r_busy;
  assign done_o   = r_done;
  assign result_o = r_result;
  assign cout_o   = r_cout;
  assign ovf_o    = r_ovf;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// tb/tb_alu_serial_ctrl.sv - scoreboard bench for the bit-serial ALU sequencer
module tb_alu_serial_ctrl;
  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic         cin_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         busy_o, done_o, cout_o, ovf_o;
  logic [W-1:0] result_o;
  logic         slice_a_o, slice_b_o, slice_cin_o;
  logic [1:0]   slice_sel_o;
  logic         slice_d_i, slice_cout_i;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .cin_i(cin_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
    .cout_o(cout_o), .ovf_o(ovf_o), .slice_a_o(slice_a_o), .slice_b_o(slice_b_o),
    .slice_cin_o(slice_cin_o), .slice_sel_o(slice_sel_o), .slice_d_i(slice_d_i),
    .slice_cout_i(slice_cout_i)
  );

  always #5 clk_i = ~clk_i;

  // 1-bit arithmetic slice
  logic bx;
  always_comb begin
    case (slice_sel_o)
      2'b00:   bx = slice_b_o;
      2'b01:   bx = ~slice_b_o;
      2'b10:   bx = 1'b0;
      default: bx = 1'b1;
    endcase
  end
  assign slice_d_i    = slice_a_o ^ bx ^ slice_cin_o;
  assign slice_cout_i = (slice_a_o & bx) | (slice_a_o & slice_cin_o) | (bx & slice_cin_o);

  // Word-level reference: full-width add with an extra carry bit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic cin);
    logic [W-1:0] opb;
    logic [W:0]   sum;
    exp_t e;
    case (op)
      2'b00:   opb = b;
      2'b01:   opb = ~b;
      2'b10:   opb = '0;
      default: opb = '1;
    endcase
    sum    = {1'b0, a} + {1'b0, opb} + {{W{1'b0}}, cin};
    e.res  = sum[W-1:0];
    e.cout = sum[W];
    e.ovf  = (a[W-1] == opb[W-1]) && (sum[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && done_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result_o, e.res);
          chk("cout", cout_o, e.cout);
          chk("ovf", ovf_o, e.ovf);
        end
      end
    end
  end

  // mode 0: plain, 1: start pulse at bit 10, 2: reset at bit 17
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] op, input logic cin, input int mode);
    exp_t e;
    int n;
    e = model(a, b, op, cin);
    @(negedge clk_i);
    a_i = a; b_i = b; op_i = op; cin_i = cin; start_i = 1'b1;
    if (mode != 2) exp_q.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    a_i = $urandom; b_i = $urandom; op_i = 2'($urandom); cin_i = 1'($urandom);
    n = 1;
    chk("busy_run", busy_o, 1);
    while (!done_o && n < 100) begin
      if (mode == 1 && n == 11) begin
        start_i = 1'b1; a_i = $urandom; b_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      if (mode == 2 && n == 18) begin
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        chk("abort_busy", busy_o, 0);
        chk("abort_done", done_o, 0);
        chk("abort_result", result_o, 0);
        chk("abort_flags", {cout_o, ovf_o}, 0);
        return;
      end
      @(negedge clk_i);
      n++;
    end
    start_i = 1'b0;
    chk("latency", n, W + 1);
    chk("busy_at_done", busy_o, 1);
    @(negedge clk_i);
    chk("done_one_cycle", done_o, 0);
    chk("busy_drop", busy_o, 0);
    chk("result_held", result_o, e.res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_i = 32'hA5A5_A5A5; b_i = 32'h5A5A_5A5A; op_i = 2'b11; cin_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", {cout_o, ovf_o}, 0);
    chk("rst_slice", {slice_a_o, slice_b_o, slice_cin_o, slice_sel_o}, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_slice", {slice_a_o, slice_b_o, slice_cin_o, slice_sel_o}, 0);

    do_op(32'd5, 32'd3, 2'b00, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 2'b00, 1'b0, 0);
    do_op(32'd5, 32'd3, 2'b01, 1'b1, 0);
    do_op(32'd3, 32'd5, 2'b01, 1'b1, 0);
    do_op(32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0, 0);
    do_op(32'h7FFF_FFFF, 32'h1234_5678, 2'b10, 1'b1, 0);
    do_op(32'h0000_1111, 32'h0000_2222, 2'b00, 1'b0, 1);
    do_op(32'h8000_0000, 32'h8000_0000, 2'b00, 1'b0, 2);
    do_op(32'd5, 32'd3, 2'b00, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      do_op($urandom, $urandom, 2'($urandom), 1'($urandom), 0);
    end

    repeat (3) @(negedge clk_i);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
